// File: rtl/npc_pkg.sv
// Shared NPC core definitions: XLEN, load funct3 encodings, writeback state and slot payload.
package npc_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned REG_AW = 5;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } wb_state_e;

    // Registered writeback slot; we already has the x0 suppression folded in.
    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_slot_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data aligner: shifts the raw memory word by the byte offset and sign/zero-extends
// to XLEN according to the load funct3.
module load_align
    import npc_pkg::*;
(
    input  logic [XLEN-1:0] in_data,
    input  logic [2:0]      in_addr_lo,
    input  logic [2:0]      in_funct3,
    output logic [XLEN-1:0] data_c
);

    logic [5:0]      w_shamt;
    logic [XLEN-1:0] w_shifted;

    assign w_shamt   = {in_addr_lo, 3'b000};
    assign w_shifted = in_data >> w_shamt;

    always_comb begin
        data_c = '0;
        case (in_funct3)
            F3_LB:   data_c = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
            F3_LH:   data_c = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            F3_LW:   data_c = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
            F3_LD:   data_c = w_shifted;
            F3_LBU:  data_c = {{(XLEN-8){1'b0}},  w_shifted[7:0]};
            F3_LHU:  data_c = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            F3_LWU:  data_c = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
            default: data_c = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// NPC writeback stage: one-deep registered slot feeding the register file write port and
// forwarding path, retire counter and ebreak halt FSM. WB_COMMIT_TRACE_EN adds commit_valid/commit_pc.
module wb_stage
    import npc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_wen,
    input  logic [XLEN-1:0]   in_result,
    input  logic              in_is_load,
    input  logic [2:0]        in_ld_funct3,
    input  logic [2:0]        in_addr_lo,
    input  logic [XLEN-1:0]   in_ld_data,
    input  logic              in_halt,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [XLEN-1:0]   fwd_data,
    output logic [XLEN-1:0]   retire_cnt,
    output logic              halted
`ifdef WB_COMMIT_TRACE_EN
    ,
    output logic              commit_valid,
    output logic [XLEN-1:0]   commit_pc
`endif
);

    wb_state_e       r_state;
    wb_state_e       w_state_nxt;
    wb_slot_t        r_slot;
    logic [XLEN-1:0] r_retire_cnt;
    logic [XLEN-1:0] w_ld_aligned;
    logic [XLEN-1:0] w_wb_value;
    logic            w_ready_c;
    logic            w_halted_c;
    logic            w_transfer;

    load_align u_load_align (
        .in_data    (in_ld_data),
        .in_addr_lo (in_addr_lo),
        .in_funct3  (in_ld_funct3),
        .data_c     (w_ld_aligned)
    );

    assign w_wb_value = in_is_load ? w_ld_aligned : in_result;
    assign w_transfer = in_valid && w_ready_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:  if (w_transfer && in_halt) w_state_nxt = ST_HALT;
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Ready depends on state alone so there is no in_valid -> in_ready path.
    always_comb begin
        w_ready_c  = 1'b0;
        w_halted_c = 1'b0;
        case (r_state)
            ST_RUN:  w_ready_c  = 1'b1;
            ST_HALT: w_halted_c = 1'b1;
            default: w_ready_c  = 1'b1;
        endcase
    end

    // rd/data hold their last value when the slot empties; only the write enable drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= '0;
        end else begin
            r_slot.we <= w_transfer && in_wen && (in_rd != '0);
            if (w_transfer) begin
                r_slot.rd   <= in_rd;
                r_slot.data <= w_wb_value;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= '0;
        end else if (w_transfer) begin
            r_retire_cnt <= r_retire_cnt + XLEN'(1);
        end
    end

`ifdef WB_COMMIT_TRACE_EN
    logic            r_commit_valid;
    logic [XLEN-1:0] r_commit_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_commit_valid <= 1'b0;
            r_commit_pc    <= '0;
        end else begin
            r_commit_valid <= w_transfer;
            if (w_transfer) begin
                r_commit_pc <= in_pc;
            end
        end
    end

    assign commit_valid = r_commit_valid;
    assign commit_pc    = r_commit_pc;
`else
    logic w_unused_pc;
    assign w_unused_pc = ^in_pc;
`endif

    assign in_ready   = w_ready_c;
    assign halted     = w_halted_c;
    assign rf_we      = r_slot.we;
    assign rf_waddr   = r_slot.rd;
    assign rf_wdata   = r_slot.data;
    assign fwd_valid  = r_slot.we;
    assign fwd_rd     = r_slot.rd;
    assign fwd_data   = r_slot.data;
    assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage (default build): directed test-plan vectors plus
// randomized transfers against a byte-level load/writeback reference model.
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic [63:0] in_result;
    logic        in_is_load;
    logic [2:0]  in_ld_funct3;
    logic [2:0]  in_addr_lo;
    logic [63:0] in_ld_data;
    logic        in_halt;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [63:0] fwd_data;
    logic [63:0] retire_cnt;
    logic        halted;

    int          n_checks;
    int          n_errors;
    logic [63:0] exp_cnt;

    wb_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_rd        (in_rd),
        .in_wen       (in_wen),
        .in_result    (in_result),
        .in_is_load   (in_is_load),
        .in_ld_funct3 (in_ld_funct3),
        .in_addr_lo   (in_addr_lo),
        .in_ld_data   (in_ld_data),
        .in_halt      (in_halt),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .fwd_valid    (fwd_valid),
        .fwd_rd       (fwd_rd),
        .fwd_data     (fwd_data),
        .retire_cnt   (retire_cnt),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: pick access size and signedness, then mask and extend with plain arithmetic.
    function automatic logic [63:0] ref_align(input logic [63:0] d, input logic [2:0] a,
                                              input logic [2:0] f3);
        logic [63:0] s;
        logic [63:0] mask;
        int          nbytes;
        bit          sgn;
        s = d >> (8 * int'(a));
        case (f3)
            3'd0: begin nbytes = 1; sgn = 1'b1; end
            3'd1: begin nbytes = 2; sgn = 1'b1; end
            3'd2: begin nbytes = 4; sgn = 1'b1; end
            3'd3: begin nbytes = 8; sgn = 1'b0; end
            3'd4: begin nbytes = 1; sgn = 1'b0; end
            3'd5: begin nbytes = 2; sgn = 1'b0; end
            3'd6: begin nbytes = 4; sgn = 1'b0; end
            default: return 64'd0;
        endcase
        mask = (nbytes == 8) ? {64{1'b1}} : ((64'd1 << (8 * nbytes)) - 64'd1);
        s = s & mask;
        if (sgn && s[8 * nbytes - 1]) s = s | ~mask;
        return s;
    endfunction

    task automatic apply(input logic v, input logic [4:0] rd, input logic wen,
                         input logic [63:0] res, input logic ld, input logic [2:0] f3,
                         input logic [2:0] a, input logic [63:0] d, input logic h);
        in_valid     = v;
        in_pc        = {$urandom, $urandom};
        in_rd        = rd;
        in_wen       = wen;
        in_result    = res;
        in_is_load   = ld;
        in_ld_funct3 = f3;
        in_addr_lo   = a;
        in_ld_data   = d;
        in_halt      = h;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        apply(1'b0, 5'd0, 1'b0, 64'd0, 1'b0, 3'd0, 3'd0, 64'd0, 1'b0);
        apply(1'b0, 5'd0, 1'b0, 64'd0, 1'b0, 3'd0, 3'd0, 64'd0, 1'b0);
        exp_cnt = 64'd0;
        n_checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 64'd0) begin
            n_errors++;
            $display("FAIL reset_rf: got we=%0b waddr=%0d wdata=%h want 0/0/0", rf_we, rf_waddr, rf_wdata);
        end
        n_checks++;
        if (fwd_valid !== 1'b0 || fwd_rd !== 5'd0 || fwd_data !== 64'd0) begin
            n_errors++;
            $display("FAIL reset_fwd: got v=%0b rd=%0d data=%h want 0/0/0", fwd_valid, fwd_rd, fwd_data);
        end
        n_checks++;
        if (retire_cnt !== 64'd0 || halted !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_state: got cnt=%0d halted=%0b ready=%0b want 0/0/1", retire_cnt, halted, in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        apply(1'b1, 5'd5, 1'b1, 64'h1234, 1'b0, 3'd0, 3'd0, 64'hFFFF, 1'b0);
        exp_cnt++;
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 64'h1234 || retire_cnt !== 64'd1) begin
            n_errors++;
            $display("FAIL alu_rd5: got we=%0b waddr=%0d wdata=%h cnt=%0d want 1/5/1234/1", rf_we, rf_waddr, rf_wdata, retire_cnt);
        end
        n_checks++;
        if (fwd_valid !== 1'b1 || fwd_rd !== 5'd5 || fwd_data !== 64'h1234) begin
            n_errors++;
            $display("FAIL alu_fwd: got v=%0b rd=%0d data=%h want 1/5/1234", fwd_valid, fwd_rd, fwd_data);
        end
        apply(1'b1, 5'd6, 1'b1, 64'd0, 1'b1, 3'd0, 3'd1, 64'h0000_0000_0000_80FF, 1'b0);
        exp_cnt++;
        n_checks++;
        if (rf_wdata !== 64'hFFFF_FFFF_FFFF_FF80) begin
            n_errors++;
            $display("FAIL lb: got %h want ffffffffffffff80", rf_wdata);
        end
        apply(1'b1, 5'd6, 1'b1, 64'd0, 1'b1, 3'd4, 3'd1, 64'h0000_0000_0000_80FF, 1'b0);
        exp_cnt++;
        n_checks++;
        if (rf_wdata !== 64'h80) begin
            n_errors++;
            $display("FAIL lbu: got %h want 80", rf_wdata);
        end
        apply(1'b1, 5'd7, 1'b1, 64'd0, 1'b1, 3'd2, 3'd4, 64'h8000_0001_0000_0000, 1'b0);
        exp_cnt++;
        n_checks++;
        if (rf_wdata !== 64'hFFFF_FFFF_8000_0001) begin
            n_errors++;
            $display("FAIL lw: got %h want ffffffff80000001", rf_wdata);
        end
        apply(1'b1, 5'd7, 1'b1, 64'd0, 1'b1, 3'd6, 3'd4, 64'h8000_0001_0000_0000, 1'b0);
        exp_cnt++;
        n_checks++;
        if (rf_wdata !== 64'h0000_0000_8000_0001) begin
            n_errors++;
            $display("FAIL lwu: got %h want 80000001", rf_wdata);
        end
        apply(1'b1, 5'd0, 1'b1, 64'hDEAD, 1'b0, 3'd0, 3'd0, 64'd0, 1'b0);
        exp_cnt++;
        n_checks++;
        if (rf_we !== 1'b0 || fwd_valid !== 1'b0 || retire_cnt !== exp_cnt) begin
            n_errors++;
            $display("FAIL x0_write: got we=%0b fwd=%0b cnt=%0d want 0/0/%0d", rf_we, fwd_valid, retire_cnt, exp_cnt);
        end
        apply(1'b0, 5'd9, 1'b1, 64'h55, 1'b0, 3'd0, 3'd0, 64'd0, 1'b0);
        n_checks++;
        if (rf_we !== 1'b0 || retire_cnt !== exp_cnt) begin
            n_errors++;
            $display("FAIL idle: got we=%0b cnt=%0d want 0/%0d", rf_we, retire_cnt, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        apply(1'b1, 5'd12, 1'b1, 64'hAAAA, 1'b0, 3'd0, 3'd0, 64'd0, 1'b0);
        exp_cnt++;
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 64'hAAAA) begin
            n_errors++;
            $display("FAIL b2b_first: got we=%0b waddr=%0d wdata=%h want 1/12/aaaa", rf_we, rf_waddr, rf_wdata);
        end
        apply(1'b1, 5'd12, 1'b1, 64'hBBBB, 1'b0, 3'd0, 3'd0, 64'd0, 1'b0);
        exp_cnt++;
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 64'hBBBB || retire_cnt !== exp_cnt) begin
            n_errors++;
            $display("FAIL b2b_second: got we=%0b waddr=%0d wdata=%h cnt=%0d want 1/12/bbbb/%0d", rf_we, rf_waddr, rf_wdata, retire_cnt, exp_cnt);
        end
    endtask

    task automatic test_random();
        logic        v;
        logic        wen;
        logic        ld;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [2:0]  a;
        logic [63:0] res;
        logic [63:0] d;
        logic [63:0] exp_data;
        for (int i = 0; i < 300; i++) begin
            v   = ($urandom_range(0, 9) < 7);
            wen = 1'($urandom);
            ld  = 1'($urandom);
            rd  = 5'($urandom);
            f3  = 3'($urandom);
            a   = 3'($urandom);
            res = {$urandom, $urandom};
            d   = {$urandom, $urandom};
            exp_data = ld ? ref_align(d, a, f3) : res;
            apply(v, rd, wen, res, ld, f3, a, d, 1'b0);
            if (v) exp_cnt++;
            n_checks++;
            if (rf_we !== (v && wen && rd != 5'd0) || fwd_valid !== rf_we) begin
                n_errors++;
                $display("FAIL rand_we[%0d]: got we=%0b fwd=%0b want %0b", i, rf_we, fwd_valid, v && wen && rd != 5'd0);
            end
            if (v) begin
                n_checks++;
                if (rf_waddr !== rd || rf_wdata !== exp_data || fwd_rd !== rd || fwd_data !== exp_data) begin
                    n_errors++;
                    $display("FAIL rand_data[%0d]: got waddr=%0d wdata=%h want %0d/%h (ld=%0b f3=%0d a=%0d)", i, rf_waddr, rf_wdata, rd, exp_data, ld, f3, a);
                end
            end
            n_checks++;
            if (retire_cnt !== exp_cnt || in_ready !== 1'b1 || halted !== 1'b0) begin
                n_errors++;
                $display("FAIL rand_cnt[%0d]: got cnt=%0d ready=%0b halted=%0b want %0d/1/0", i, retire_cnt, in_ready, halted, exp_cnt);
            end
        end
    endtask

    task automatic test_halt();
        n_checks++;
        if (in_ready !== 1'b1 || halted !== 1'b0) begin
            n_errors++;
            $display("FAIL pre_halt: got ready=%0b halted=%0b want 1/0", in_ready, halted);
        end
        apply(1'b1, 5'd10, 1'b1, 64'd7, 1'b0, 3'd0, 3'd0, 64'd0, 1'b1);
        exp_cnt++;
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 64'd7 || retire_cnt !== exp_cnt) begin
            n_errors++;
            $display("FAIL halt_wb: got we=%0b waddr=%0d wdata=%h cnt=%0d want 1/10/7/%0d", rf_we, rf_waddr, rf_wdata, retire_cnt, exp_cnt);
        end
        n_checks++;
        if (in_ready !== 1'b0 || halted !== 1'b1) begin
            n_errors++;
            $display("FAIL halt_state: got ready=%0b halted=%0b want 0/1", in_ready, halted);
        end
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 5'd11, 1'b1, 64'h99, 1'b0, 3'd0, 3'd0, 64'd0, 1'($urandom));
            n_checks++;
            if (rf_we !== 1'b0 || retire_cnt !== exp_cnt || in_ready !== 1'b0 || halted !== 1'b1) begin
                n_errors++;
                $display("FAIL halted_ignore[%0d]: got we=%0b cnt=%0d ready=%0b halted=%0b want 0/%0d/0/1", i, rf_we, retire_cnt, in_ready, halted, exp_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        // Recover from HALT through reset, then fill the slot and reset inside the cycle.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        exp_cnt = 64'd0;
        n_checks++;
        if (in_ready !== 1'b1 || halted !== 1'b0 || retire_cnt !== 64'd0) begin
            n_errors++;
            $display("FAIL reset_from_halt: got ready=%0b halted=%0b cnt=%0d want 1/0/0", in_ready, halted, retire_cnt);
        end
        apply(1'b1, 5'd3, 1'b1, 64'h77, 1'b0, 3'd0, 3'd0, 64'd0, 1'b0);
        exp_cnt++;
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || retire_cnt !== 64'd1) begin
            n_errors++;
            $display("FAIL pre_mid_reset: got we=%0b waddr=%0d cnt=%0d want 1/3/1", rf_we, rf_waddr, retire_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 64'd0 || fwd_valid !== 1'b0 ||
            fwd_data !== 64'd0 || retire_cnt !== 64'd0 || in_ready !== 1'b1 || halted !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset: got we=%0b waddr=%0d wdata=%h fwd=%0b cnt=%0d ready=%0b halted=%0b want all 0, ready=1", rf_we, rf_waddr, rf_wdata, fwd_valid, retire_cnt, in_ready, halted);
        end
        apply(1'b1, 5'd4, 1'b1, 64'h88, 1'b0, 3'd0, 3'd0, 64'd0, 1'b0);
        n_checks++;
        if (rf_we !== 1'b0 || retire_cnt !== 64'd0) begin
            n_errors++;
            $display("FAIL held_in_reset: got we=%0b cnt=%0d want 0/0", rf_we, retire_cnt);
        end
        rst_n = 1'b1;
        apply(1'b1, 5'd4, 1'b1, 64'h88, 1'b0, 3'd0, 3'd0, 64'd0, 1'b0);
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 64'h88 || retire_cnt !== 64'd1) begin
            n_errors++;
            $display("FAIL post_reset: got we=%0b waddr=%0d wdata=%h cnt=%0d want 1/4/88/1", rf_we, rf_waddr, rf_wdata, retire_cnt);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        exp_cnt      = 64'd0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_pc        = 64'd0;
        in_rd        = 5'd0;
        in_wen       = 1'b0;
        in_result    = 64'd0;
        in_is_load   = 1'b0;
        in_ld_funct3 = 3'd0;
        in_addr_lo   = 3'd0;
        in_ld_data   = 64'd0;
        in_halt      = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_halt();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
